// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the multi-stage reset sequencer.
// State encoding, default timing constants and counter-width helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned DEF_STAGE_DELAY = 10000;
    localparam int unsigned DEF_SIM_DELAY   = 10;
    localparam int unsigned DEF_HOLD_CYCLES = 16;
    localparam int unsigned DEF_WDT_TIMEOUT = 1000000;

    function automatic int unsigned cnt_w(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asynchronous assert, two-flop synchronous release.
// Output is low while i_rst_n is low and for two clocks after it rises.
module rst_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign o_rst_n = r_sync[1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-stage reset sequencer: ordered, evenly spaced per-subsystem release.
// Optional watchdog re-sequencing is built when RST_SEQ_WDT_EN is defined.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter bit          SIMULATION  = 1'b0,
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int unsigned SIM_DELAY   = DEF_SIM_DELAY,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned WDT_TIMEOUT = DEF_WDT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          soft_req,
    output logic                          soft_ack,
    input  logic                          wdt_kick,
    output logic [NUM_STAGES-1:0]         stage_rst_n,
    output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
    output logic                          busy,
    output logic                          all_ready,
    output logic                          wdt_fired
);

    localparam int unsigned DLY = SIMULATION ? SIM_DELAY : STAGE_DELAY;
    localparam int unsigned IW  = $clog2(NUM_STAGES);
    localparam int unsigned HW  = cnt_w(HOLD_CYCLES);
    localparam int unsigned DW  = cnt_w(DLY);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [DW-1:0] DLY_LAST  = DW'(DLY - 1);
    localparam logic [DW-1:0] DLY_MAX   = DW'(DLY);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    logic                  w_rst_n;
    logic                  w_wdt_hit;
    logic [NUM_STAGES-1:0] w_rel_mask;

    state_t                r_state;
    logic [NUM_STAGES-1:0] r_stage_rst_n;
    logic [IW-1:0]         r_idx;
    logic                  r_busy;
    logic                  r_all_ready;
    logic                  r_soft_ack;
    logic [HW-1:0]         r_hold_cnt;
    logic [DW-1:0]         r_dly_cnt;

    rst_sync u_rst_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_rst_n (w_rst_n)
    );

    assign w_rel_mask = NUM_STAGES'(1) << r_idx;

`ifdef RST_SEQ_WDT_EN
    localparam int unsigned WW = cnt_w(WDT_TIMEOUT);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_TIMEOUT - 1);
    localparam logic [WW-1:0] WDT_MAX  = WW'(WDT_TIMEOUT);

    logic [WW-1:0] r_wdt_cnt;
    logic          r_wdt_fired;

    // A kick on the timeout edge still counts as service.
    assign w_wdt_hit = (r_wdt_cnt == WDT_LAST) && !wdt_kick;
    assign wdt_fired = r_wdt_fired;
`else
    logic w_unused_kick;

    assign w_unused_kick = wdt_kick;
    assign w_wdt_hit     = 1'b0;
    assign wdt_fired     = 1'b0;
`endif

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= HOLD;
            r_stage_rst_n <= '0;
            r_idx         <= '0;
            r_busy        <= 1'b1;
            r_all_ready   <= 1'b0;
            r_soft_ack    <= 1'b0;
            r_hold_cnt    <= '0;
            r_dly_cnt     <= '0;
`ifdef RST_SEQ_WDT_EN
            r_wdt_cnt     <= '0;
            r_wdt_fired   <= 1'b0;
`endif
        end else begin
            r_soft_ack <= 1'b0;
`ifdef RST_SEQ_WDT_EN
            r_wdt_fired <= 1'b0;
`endif
            unique case (r_state)
                HOLD: begin
                    if (soft_req) begin
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_hold_cnt    <= '0;
                        r_dly_cnt     <= '0;
                        r_stage_rst_n <= NUM_STAGES'(1);
                        r_idx         <= IW'(1);
                        r_state       <= WAIT;
                    end else if (r_hold_cnt != HOLD_MAX) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (r_dly_cnt == DLY_LAST) begin
                        r_dly_cnt     <= '0;
                        r_stage_rst_n <= r_stage_rst_n | w_rel_mask;
                        if (r_idx == IDX_LAST) begin
                            r_state     <= RUN;
                            r_all_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_idx       <= '0;
`ifdef RST_SEQ_WDT_EN
                            r_wdt_cnt   <= '0;
`endif
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else if (r_dly_cnt != DLY_MAX) begin
                        r_dly_cnt <= r_dly_cnt + 1'b1;
                    end
                end
                RUN: begin
`ifdef RST_SEQ_WDT_EN
                    if (wdt_kick) begin
                        r_wdt_cnt <= '0;
                    end else if (r_wdt_cnt != WDT_MAX) begin
                        r_wdt_cnt <= r_wdt_cnt + 1'b1;
                    end
`endif
                    // A soft request takes priority over a coincident timeout.
                    if (soft_req || w_wdt_hit) begin
                        r_soft_ack    <= soft_req;
`ifdef RST_SEQ_WDT_EN
                        r_wdt_fired   <= !soft_req;
`endif
                        r_stage_rst_n <= '0;
                        r_busy        <= 1'b1;
                        r_all_ready   <= 1'b0;
                        r_hold_cnt    <= '0;
                        r_state       <= HOLD;
                    end
                end
                default: begin
                    r_state <= HOLD;
                end
            endcase
        end
    end

    assign stage_rst_n = r_stage_rst_n;
    assign stage_idx   = r_idx;
    assign busy        = r_busy;
    assign all_ready   = r_all_ready;
    assign soft_ack    = r_soft_ack;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed self-checking bench for rst_seq_ctrl (4 stages, hold 4, delay 10).
// Watchdog scenarios are included when RST_SEQ_WDT_EN is defined.
module tb_rst_seq_ctrl;

    localparam int NS  = 4;
    localparam int DLY = 10;

    logic          clk;
    logic          rst_n;
    logic          soft_req;
    logic          soft_ack;
    logic          wdt_kick;
    logic [NS-1:0] stage_rst_n;
    logic [1:0]    stage_idx;
    logic          busy;
    logic          all_ready;
    logic          wdt_fired;

    int n_chk;
    int n_fail;
    int ack_cnt;
    int fire_cnt;
    int a0;
    int f0;

    logic [NS-1:0] exp_tbl [NS];

    rst_seq_ctrl #(
        .SIMULATION  (1'b1),
        .NUM_STAGES  (NS),
        .STAGE_DELAY (10000),
        .SIM_DELAY   (DLY),
        .HOLD_CYCLES (4),
        .WDT_TIMEOUT (50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_req    (soft_req),
        .soft_ack    (soft_ack),
        .wdt_kick    (wdt_kick),
        .stage_rst_n (stage_rst_n),
        .stage_idx   (stage_idx),
        .busy        (busy),
        .all_ready   (all_ready),
        .wdt_fired   (wdt_fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (soft_ack)  ack_cnt++;
        if (wdt_fired) fire_cnt++;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // first = number of edges from now to the stage-0 release edge
    task automatic seq_check(input string tag, input int first);
        wait_n(first - 1);
        check({tag, "_hold"}, 32'(stage_rst_n), 32'h0);
        check({tag, "_hbusy"}, 32'(busy), 32'h1);
        wait_n(1);
        check({tag, "_s0"}, 32'(stage_rst_n), 32'(exp_tbl[0]));
        check({tag, "_i1"}, 32'(stage_idx), 32'h1);
        for (int k = 1; k < NS; k++) begin
            wait_n(DLY - 1);
            check({tag, "_pre"}, 32'(stage_rst_n), 32'(exp_tbl[k-1]));
            check({tag, "_prdy"}, 32'(all_ready), 32'h0);
            wait_n(1);
            check({tag, "_stg"}, 32'(stage_rst_n), 32'(exp_tbl[k]));
            if (k < NS - 1) begin
                check({tag, "_idx"}, 32'(stage_idx), 32'(k + 1));
                check({tag, "_busy"}, 32'(busy), 32'h1);
            end
        end
        check({tag, "_rdy"}, 32'(all_ready), 32'h1);
        check({tag, "_nbusy"}, 32'(busy), 32'h0);
        check({tag, "_idx0"}, 32'(stage_idx), 32'h0);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        ack_cnt  = 0;
        fire_cnt = 0;
        exp_tbl[0] = 4'b0001;
        exp_tbl[1] = 4'b0011;
        exp_tbl[2] = 4'b0111;
        exp_tbl[3] = 4'b1111;
        rst_n    = 1'b0;
        soft_req = 1'b0;
        wdt_kick = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_stg", 32'(stage_rst_n), 32'h0);
        check("rst_idx", 32'(stage_idx), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_rdy", 32'(all_ready), 32'h0);
        check("rst_ack", 32'(soft_ack), 32'h0);
        check("rst_wdt", 32'(wdt_fired), 32'h0);

        rst_n = 1'b1;
        seq_check("pwr", 6);

        a0 = ack_cnt;
        @(negedge clk) soft_req = 1'b1;
        wait_n(1);
        check("s3_ack", 32'(soft_ack), 32'h1);
        check("s3_stg", 32'(stage_rst_n), 32'h0);
        check("s3_busy", 32'(busy), 32'h1);
        check("s3_rdy", 32'(all_ready), 32'h0);
        wait_n(1);
        check("s3_ackend", 32'(soft_ack), 32'h0);
        @(posedge clk);
        @(negedge clk) soft_req = 1'b0;
        seq_check("s3", 4);
        check("s3_acks", 32'(ack_cnt - a0), 32'h1);

        @(negedge clk) soft_req = 1'b1;
        wait_n(1);
        check("w_ack0", 32'(soft_ack), 32'h1);
        @(negedge clk) soft_req = 1'b0;
        wait_n(4);
        check("w_s0", 32'(stage_rst_n), 32'h1);
        wait_n(DLY);
        check("w_s1", 32'(stage_rst_n), 32'h3);
        check("w_i2", 32'(stage_idx), 32'h2);
        @(negedge clk) soft_req = 1'b1;
        a0 = ack_cnt;
        wait_n(2 * DLY - 1);
        check("w_s2", 32'(stage_rst_n), 32'h7);
        check("w_noack", 32'(ack_cnt - a0), 32'h0);
        wait_n(1);
        check("w_s3", 32'(stage_rst_n), 32'hf);
        check("w_rdy", 32'(all_ready), 32'h1);
        check("w_ack_lo", 32'(soft_ack), 32'h0);
        wait_n(1);
        check("w_ack", 32'(soft_ack), 32'h1);
        check("w_clr", 32'(stage_rst_n), 32'h0);
        @(negedge clk) soft_req = 1'b0;
        seq_check("rerun", 4);

        @(negedge clk) soft_req = 1'b1;
        wait_n(1);
        @(negedge clk) soft_req = 1'b0;
        wait_n(4);
        check("rp_s0", 32'(stage_rst_n), 32'h1);
        wait_n(3);
        #2 rst_n = 1'b0;
        #1;
        check("rp_stg", 32'(stage_rst_n), 32'h0);
        check("rp_idx", 32'(stage_idx), 32'h0);
        check("rp_busy", 32'(busy), 32'h1);
        check("rp_rdy", 32'(all_ready), 32'h0);
        rst_n = 1'b1;
        seq_check("rp", 6);

`ifdef RST_SEQ_WDT_EN
        f0 = fire_cnt;
        wait_n(49);
        check("wd_quiet", 32'(wdt_fired), 32'h0);
        check("wd_up", 32'(stage_rst_n), 32'hf);
        wait_n(1);
        check("wd_fire", 32'(wdt_fired), 32'h1);
        check("wd_stg", 32'(stage_rst_n), 32'h0);
        check("wd_noack", 32'(soft_ack), 32'h0);
        wait_n(1);
        check("wd_pulse", 32'(wdt_fired), 32'h0);
        seq_check("wd", 3);
        check("wd_fires", 32'(fire_cnt - f0), 32'h1);

        f0 = fire_cnt;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk) wdt_kick = ((i % 40) == 39);
        end
        @(negedge clk) wdt_kick = 1'b0;
        check("kick_nofire", 32'(fire_cnt - f0), 32'h0);
        check("kick_rdy", 32'(all_ready), 32'h1);

        repeat (48) @(posedge clk);
        @(negedge clk) soft_req = 1'b1;
        a0 = ack_cnt;
        wait_n(1);
        check("co_ack", 32'(soft_ack), 32'h1);
        check("co_wdt", 32'(wdt_fired), 32'h0);
        check("co_stg", 32'(stage_rst_n), 32'h0);
        @(negedge clk) soft_req = 1'b0;
        seq_check("co", 4);
        check("co_acks", 32'(ack_cnt - a0), 32'h1);
        check("co_fires", 32'(fire_cnt - f0), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
